// File: rtl/punc_control_unit_if.sv
// -----------------------------------------------------------------------------
// punc_control_unit_if
// Bundle between the PUnC control unit and the LC3 datapath.
//   master : control unit side. It reads ir and the NZP flags and drives the
//            state/halted status plus every datapath select, load and
//            write-enable strobe.
//   slave  : datapath side. It drives ir and the flags and consumes the
//            strobes.
// -----------------------------------------------------------------------------
interface punc_control_unit_if;
  logic [15:0] ir;
  logic        n_flag;
  logic        z_flag;
  logic        p_flag;
  logic [2:0]  state;
  logic        halted;
  logic        pc_clr;
  logic        pc_inc;
  logic        pc_ld;
  logic        ir_ld;
  logic        store_ld;
  logic        nzp_ld;
  logic        pc_data_sel;
  logic        pc_add_sel;
  logic [1:0]  mem_addr_sel;
  logic        mem_w_en;
  logic [1:0]  rf_w_sel;
  logic        rf_w_en;
  logic [2:0]  rf_r_addr_0;
  logic [2:0]  rf_r_addr_1;
  logic [2:0]  rf_w_addr;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  sext_sel;
  logic [1:0]  alu_sel;
  logic        nzp_sel;

  modport master (
    input  ir, n_flag, z_flag, p_flag,
    output state, halted, pc_clr, pc_inc, pc_ld, ir_ld, store_ld, nzp_ld,
           pc_data_sel, pc_add_sel, mem_addr_sel, mem_w_en, rf_w_sel, rf_w_en,
           rf_r_addr_0, rf_r_addr_1, rf_w_addr, alu_a_sel, alu_b_sel,
           sext_sel, alu_sel, nzp_sel
  );

  modport slave (
    output ir, n_flag, z_flag, p_flag,
    input  state, halted, pc_clr, pc_inc, pc_ld, ir_ld, store_ld, nzp_ld,
           pc_data_sel, pc_add_sel, mem_addr_sel, mem_w_en, rf_w_sel, rf_w_en,
           rf_r_addr_0, rf_r_addr_1, rf_w_addr, alu_a_sel, alu_b_sel,
           sext_sel, alu_sel, nzp_sel
  );
endinterface

// File: rtl/punc_control_unit.sv
// -----------------------------------------------------------------------------
// punc_control_unit
// Control FSM for the PUnC LC3 datapath. It fetches, decodes and executes one
// instruction at a time. The only state is the FSM state. All outputs are
// combinational from the state and the instruction register.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset (forces INIT immediately)
//   bus  : punc_control_unit_if.master. It carries ir and the NZP flags in,
//          and state, halted and all datapath strobes/selects out.
// -----------------------------------------------------------------------------
module punc_control_unit (
  input  logic                  clk,
  input  logic                  rst,
  punc_control_unit_if.master   bus
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXECUTE  = 3'd3,
    ST_EXECUTE2 = 3'd4,
    ST_HALT     = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t     state_r;
  state_t     next_state_s;
  logic [3:0] opcode_s;
  logic       unused_ir_bits_s;

  // The branch condition field in IR[11:9] is matched against the flags.
  function automatic logic br_taken(input logic [2:0] cond,
                                    input logic n, input logic z, input logic p);
    return (cond[2] & n) | (cond[1] & z) | (cond[0] & p);
  endfunction

  assign opcode_s         = bus.ir[15:12];
  // IR[4:3] only distinguishes encodings that the control unit never needs to tell apart.
  assign unused_ir_bits_s = ^bus.ir[4:3];
  assign bus.state        = state_r;

  // State register. Reset is asynchronous, so write strobes drop as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing.
  always_comb begin
    next_state_s = ST_INIT;
    case (state_r)
      ST_INIT:     next_state_s = ST_FETCH;
      ST_FETCH:    next_state_s = ST_DECODE;
      ST_DECODE: begin
        if (opcode_s == OP_TRAP) begin
          next_state_s = ST_HALT;
        end else begin
          next_state_s = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if ((opcode_s == OP_LDI) || (opcode_s == OP_STI)) begin
          next_state_s = ST_EXECUTE2;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_EXECUTE2: next_state_s = ST_FETCH;
      ST_HALT:     next_state_s = ST_HALT;
      default:     next_state_s = ST_INIT;
    endcase
  end

  // Datapath control decode from state and opcode.
  always_comb begin
    bus.halted       = 1'b0;
    bus.pc_clr       = 1'b0;
    bus.pc_inc       = 1'b0;
    bus.pc_ld        = 1'b0;
    bus.ir_ld        = 1'b0;
    bus.store_ld     = 1'b0;
    bus.nzp_ld       = 1'b0;
    bus.pc_data_sel  = 1'b0;
    bus.pc_add_sel   = 1'b0;
    bus.mem_addr_sel = 2'b00;
    bus.mem_w_en     = 1'b0;
    bus.rf_w_sel     = 2'b00;
    bus.rf_w_en      = 1'b0;
    bus.rf_r_addr_0  = 3'd0;
    bus.rf_r_addr_1  = 3'd0;
    bus.rf_w_addr    = 3'd0;
    bus.alu_a_sel    = 1'b0;
    bus.alu_b_sel    = 1'b0;
    bus.sext_sel     = 2'b00;
    bus.alu_sel      = 2'b00;
    bus.nzp_sel      = 1'b0;
    case (state_r)
      ST_INIT: bus.pc_clr = 1'b1;
      ST_FETCH: begin
        bus.mem_addr_sel = 2'b00;
        bus.ir_ld        = 1'b1;
        bus.pc_inc       = 1'b1;
      end
      ST_DECODE: bus.halted = 1'b0;
      ST_EXECUTE: begin
        case (opcode_s)
          OP_ADD, OP_AND: begin
            bus.rf_r_addr_0 = bus.ir[8:6];
            bus.rf_r_addr_1 = bus.ir[2:0];
            bus.alu_a_sel   = 1'b1;
            bus.alu_b_sel   = bus.ir[5];
            bus.sext_sel    = 2'b00;
            bus.alu_sel     = (opcode_s == OP_AND) ? 2'b01 : 2'b00;
            bus.rf_w_sel    = 2'b10;
            bus.rf_w_en     = 1'b1;
            bus.rf_w_addr   = bus.ir[11:9];
            bus.nzp_ld      = 1'b1;
          end
          OP_NOT: begin
            bus.rf_r_addr_0 = bus.ir[8:6];
            bus.alu_a_sel   = 1'b1;
            bus.alu_sel     = 2'b11;
            bus.rf_w_sel    = 2'b10;
            bus.rf_w_en     = 1'b1;
            bus.rf_w_addr   = bus.ir[11:9];
            bus.nzp_ld      = 1'b1;
          end
          OP_BR: begin
            if (br_taken(bus.ir[11:9], bus.n_flag, bus.z_flag, bus.p_flag)) begin
              bus.pc_ld      = 1'b1;
              bus.pc_add_sel = 1'b1;
            end else begin
              bus.pc_ld      = 1'b0;
            end
          end
          OP_JMP: begin
            bus.pc_ld       = 1'b1;
            bus.pc_data_sel = 1'b1;
            bus.rf_r_addr_0 = bus.ir[8:6];
          end
          OP_JSR: begin
            // R7 gets the incremented PC. JSRR via R7 still jumps to the old R7,
            // because the base register is read before the write edge.
            bus.rf_w_en   = 1'b1;
            bus.rf_w_sel  = 2'b00;
            bus.rf_w_addr = 3'd7;
            bus.pc_ld     = 1'b1;
            if (bus.ir[11]) begin
              bus.pc_data_sel = 1'b0;
              bus.pc_add_sel  = 1'b0;
            end else begin
              bus.pc_data_sel = 1'b1;
              bus.rf_r_addr_0 = bus.ir[8:6];
            end
          end
          OP_LD, OP_LDR, OP_ST, OP_STR: begin
            // Effective address is formed in the ALU: PC+offset9 or base+offset6.
            bus.alu_b_sel    = 1'b1;
            bus.alu_sel      = 2'b00;
            bus.mem_addr_sel = 2'b01;
            if ((opcode_s == OP_LDR) || (opcode_s == OP_STR)) begin
              bus.alu_a_sel   = 1'b1;
              bus.rf_r_addr_0 = bus.ir[8:6];
              bus.sext_sel    = 2'b01;
            end else begin
              bus.alu_a_sel   = 1'b0;
              bus.sext_sel    = 2'b10;
            end
            if ((opcode_s == OP_LD) || (opcode_s == OP_LDR)) begin
              bus.rf_w_sel  = 2'b01;
              bus.rf_w_en   = 1'b1;
              bus.rf_w_addr = bus.ir[11:9];
              bus.nzp_ld    = 1'b1;
              bus.nzp_sel   = 1'b1;
            end else begin
              bus.mem_w_en    = 1'b1;
              bus.rf_r_addr_1 = bus.ir[11:9];
            end
          end
          OP_LEA: begin
            bus.alu_a_sel = 1'b0;
            bus.alu_b_sel = 1'b1;
            bus.sext_sel  = 2'b10;
            bus.alu_sel   = 2'b00;
            bus.rf_w_sel  = 2'b10;
            bus.rf_w_en   = 1'b1;
            bus.rf_w_addr = bus.ir[11:9];
          end
          OP_LDI, OP_STI: begin
            // First pass reads the pointer word into the store register.
            bus.alu_a_sel    = 1'b0;
            bus.alu_b_sel    = 1'b1;
            bus.sext_sel     = 2'b10;
            bus.alu_sel      = 2'b00;
            bus.mem_addr_sel = 2'b01;
            bus.store_ld     = 1'b1;
          end
          default: bus.halted = 1'b0;
        endcase
      end
      ST_EXECUTE2: begin
        bus.mem_addr_sel = 2'b10;
        if (opcode_s == OP_LDI) begin
          bus.rf_w_sel  = 2'b01;
          bus.rf_w_en   = 1'b1;
          bus.rf_w_addr = bus.ir[11:9];
          bus.nzp_ld    = 1'b1;
          bus.nzp_sel   = 1'b1;
        end else if (opcode_s == OP_STI) begin
          bus.mem_w_en    = 1'b1;
          bus.rf_r_addr_1 = bus.ir[11:9];
        end else begin
          bus.mem_w_en    = 1'b0;
        end
      end
      ST_HALT: bus.halted = 1'b1;
      default: bus.pc_clr = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_punc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_punc_control_unit
// Directed bench for punc_control_unit. The stimulus pushes hand-computed
// expected output vectors, tagged with the cycle they belong to. A monitor
// samples the DUT on each falling edge and compares every entry due in that
// cycle.
// -----------------------------------------------------------------------------
module tb_punc_control_unit;

  typedef struct packed {
    logic [2:0] state;
    logic       halted;
    logic       pc_clr;
    logic       pc_inc;
    logic       pc_ld;
    logic       ir_ld;
    logic       store_ld;
    logic       nzp_ld;
    logic       pc_data_sel;
    logic       pc_add_sel;
    logic [1:0] mem_addr_sel;
    logic       mem_w_en;
    logic [1:0] rf_w_sel;
    logic       rf_w_en;
    logic [2:0] rf_r_addr_0;
    logic [2:0] rf_r_addr_1;
    logic [2:0] rf_w_addr;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] sext_sel;
    logic [1:0] alu_sel;
    logic       nzp_sel;
  } outs_t;

  typedef struct {
    string name;
    int    cyc;
    outs_t exp;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  sb_item_t sb_q[$];
  sb_item_t mon_it;
  outs_t    act_s;

  punc_control_unit_if bus ();

  punc_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign act_s = '{state: bus.state, halted: bus.halted, pc_clr: bus.pc_clr,
                   pc_inc: bus.pc_inc, pc_ld: bus.pc_ld, ir_ld: bus.ir_ld,
                   store_ld: bus.store_ld, nzp_ld: bus.nzp_ld,
                   pc_data_sel: bus.pc_data_sel, pc_add_sel: bus.pc_add_sel,
                   mem_addr_sel: bus.mem_addr_sel, mem_w_en: bus.mem_w_en,
                   rf_w_sel: bus.rf_w_sel, rf_w_en: bus.rf_w_en,
                   rf_r_addr_0: bus.rf_r_addr_0, rf_r_addr_1: bus.rf_r_addr_1,
                   rf_w_addr: bus.rf_w_addr, alu_a_sel: bus.alu_a_sel,
                   alu_b_sel: bus.alu_b_sel, sext_sel: bus.sext_sel,
                   alu_sel: bus.alu_sel, nzp_sel: bus.nzp_sel};

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while ((sb_q.size() != 0) && (sb_q[0].cyc == cyc_cnt)) begin
      mon_it = sb_q.pop_front();
      n_checks++;
      if (act_s !== mon_it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                 mon_it.name, act_s, mon_it.exp, act_s.state, mon_it.exp.state);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic outs_t st(input logic [2:0] s);
    outs_t o;
    o = '0;
    o.state = s;
    return o;
  endfunction

  function automatic outs_t init_v();
    outs_t o;
    o = st(3'd0);
    o.pc_clr = 1'b1;
    return o;
  endfunction

  function automatic outs_t fetch_v();
    outs_t o;
    o = st(3'd1);
    o.ir_ld  = 1'b1;
    o.pc_inc = 1'b1;
    return o;
  endfunction

  task automatic expect_now(input string name, input outs_t e);
    sb_item_t it;
    it.name = name;
    it.cyc  = cyc_cnt;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of a FETCH cycle; returns at the start of the next one.
  task automatic run_instr(input string name, input logic [15:0] iv,
                           input logic [2:0] nzp, input outs_t e3,
                           input bit two, input outs_t e4);
    expect_now({name, "_fetch"}, fetch_v());
    bus.ir = iv;
    {bus.n_flag, bus.z_flag, bus.p_flag} = nzp;
    step();
    expect_now({name, "_decode"}, st(3'd2));
    step();
    expect_now({name, "_exec"}, e3);
    if (two) begin
      step();
      expect_now({name, "_exec2"}, e4);
    end
    step();
  endtask

  initial begin
    outs_t e;
    outs_t e2;
    bus.ir = 16'h0000;
    bus.n_flag = 1'b0;
    bus.z_flag = 1'b0;
    bus.p_flag = 1'b0;
    e2 = '0;

    // Reset held across a clock edge, then released.
    step();
    expect_now("reset_state", init_v());
    step();
    expect_now("reset_over_edge", init_v());
    rst = 1'b0;
    expect_now("init_after_release", init_v());
    step();

    // ADD R1,R2,R3
    e = st(3'd3);
    e.rf_r_addr_0 = 3'd2; e.rf_r_addr_1 = 3'd3; e.alu_a_sel = 1'b1;
    e.rf_w_sel = 2'b10; e.rf_w_en = 1'b1; e.rf_w_addr = 3'd1; e.nzp_ld = 1'b1;
    run_instr("add", 16'h1283, 3'b000, e, 1'b0, e2);

    // AND R5,R1,#-1
    e = st(3'd3);
    e.rf_r_addr_0 = 3'd1; e.rf_r_addr_1 = 3'd7; e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1;
    e.alu_sel = 2'b01; e.rf_w_sel = 2'b10; e.rf_w_en = 1'b1; e.rf_w_addr = 3'd5;
    e.nzp_ld = 1'b1;
    run_instr("and_imm", 16'h5A7F, 3'b000, e, 1'b0, e2);

    // NOT R1,R1
    e = st(3'd3);
    e.rf_r_addr_0 = 3'd1; e.alu_a_sel = 1'b1; e.alu_sel = 2'b11;
    e.rf_w_sel = 2'b10; e.rf_w_en = 1'b1; e.rf_w_addr = 3'd1; e.nzp_ld = 1'b1;
    run_instr("not", 16'h927F, 3'b000, e, 1'b0, e2);

    // BRnp +5 with z set: not taken; with n set: taken.
    run_instr("brnp_z", 16'h0A05, 3'b010, st(3'd3), 1'b0, e2);
    e = st(3'd3);
    e.pc_ld = 1'b1; e.pc_add_sel = 1'b1;
    run_instr("brnp_n", 16'h0A05, 3'b100, e, 1'b0, e2);
    run_instr("br_none", 16'h0005, 3'b111, st(3'd3), 1'b0, e2);
    run_instr("brnzp_p", 16'h0E05, 3'b001, e, 1'b0, e2);

    // JMP R7
    e = st(3'd3);
    e.pc_ld = 1'b1; e.pc_data_sel = 1'b1; e.rf_r_addr_0 = 3'd7;
    run_instr("jmp", 16'hC1C0, 3'b000, e, 1'b0, e2);

    // JSR -2 and JSRR R7
    e = st(3'd3);
    e.rf_w_en = 1'b1; e.rf_w_addr = 3'd7; e.pc_ld = 1'b1;
    run_instr("jsr", 16'h4FFE, 3'b000, e, 1'b0, e2);
    e.pc_data_sel = 1'b1; e.rf_r_addr_0 = 3'd7;
    run_instr("jsrr_r7", 16'h41C0, 3'b000, e, 1'b0, e2);

    // LD R3,#+3 (PC-relative)
    e = st(3'd3);
    e.alu_b_sel = 1'b1; e.sext_sel = 2'b10; e.mem_addr_sel = 2'b01;
    e.rf_w_sel = 2'b01; e.rf_w_en = 1'b1; e.rf_w_addr = 3'd3;
    e.nzp_ld = 1'b1; e.nzp_sel = 1'b1;
    run_instr("ld", 16'h2603, 3'b000, e, 1'b0, e2);

    // LDR R5,R1,#2
    e = st(3'd3);
    e.rf_r_addr_0 = 3'd1; e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1; e.sext_sel = 2'b01;
    e.mem_addr_sel = 2'b01; e.rf_w_sel = 2'b01; e.rf_w_en = 1'b1; e.rf_w_addr = 3'd5;
    e.nzp_ld = 1'b1; e.nzp_sel = 1'b1;
    run_instr("ldr", 16'h6A42, 3'b000, e, 1'b0, e2);

    // STR R5,R1,#2
    e = st(3'd3);
    e.rf_r_addr_0 = 3'd1; e.rf_r_addr_1 = 3'd5; e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1;
    e.sext_sel = 2'b01; e.mem_addr_sel = 2'b01; e.mem_w_en = 1'b1;
    run_instr("str", 16'h7A42, 3'b000, e, 1'b0, e2);

    // LEA R0,#-1
    e = st(3'd3);
    e.alu_b_sel = 1'b1; e.sext_sel = 2'b10; e.rf_w_sel = 2'b10; e.rf_w_en = 1'b1;
    run_instr("lea", 16'hE1FF, 3'b000, e, 1'b0, e2);

    // NOP opcode 1000
    run_instr("nop", 16'h8000, 3'b000, st(3'd3), 1'b0, e2);

    // LDI R2,#+3: two execute cycles.
    e = st(3'd3);
    e.alu_b_sel = 1'b1; e.sext_sel = 2'b10; e.mem_addr_sel = 2'b01; e.store_ld = 1'b1;
    e2 = st(3'd4);
    e2.mem_addr_sel = 2'b10; e2.rf_w_sel = 2'b01; e2.rf_w_en = 1'b1; e2.rf_w_addr = 3'd2;
    e2.nzp_ld = 1'b1; e2.nzp_sel = 1'b1;
    run_instr("ldi", 16'hA403, 3'b000, e, 1'b1, e2);

    // STI R3,#+3
    e2 = st(3'd4);
    e2.mem_addr_sel = 2'b10; e2.mem_w_en = 1'b1; e2.rf_r_addr_1 = 3'd3;
    run_instr("sti", 16'hB603, 3'b000, e, 1'b1, e2);

    // STI aborted by reset in EXECUTE2: INIT and no write before the next edge.
    expect_now("sti_abort_fetch", fetch_v());
    bus.ir = 16'hB603;
    step();
    expect_now("sti_abort_decode", st(3'd2));
    step();
    expect_now("sti_abort_exec", e);
    step();
    rst = 1'b1;
    expect_now("sti_abort_reset", init_v());
    step();
    expect_now("sti_abort_held", init_v());
    rst = 1'b0;
    step();

    // TRAP: halt and stay there until reset.
    expect_now("trap_fetch", fetch_v());
    bus.ir = 16'hF025;
    step();
    expect_now("trap_decode", st(3'd2));
    step();
    e = st(3'd5);
    e.halted = 1'b1;
    for (int i = 0; i < 12; i++) begin
      expect_now($sformatf("halt_%0d", i), e);
      step();
    end
    rst = 1'b1;
    expect_now("halt_reset", init_v());
    step();
    rst = 1'b0;
    expect_now("halt_reset_released", init_v());
    step();
    expect_now("post_halt_fetch", fetch_v());

    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/punc_control_unit.md
# punc_control_unit

Control FSM that sequences the PUnC LC3 datapath. It fetches, decodes and executes one instruction at a time. It reads the instruction register and NZP flags from the datapath and drives every datapath select, load and write-enable strobe. It sits beside the datapath inside the PUnC top level, and its only state is the FSM state.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- ir  in  16  current instruction register contents
- n_flag, z_flag, p_flag  in  1 each  datapath condition codes
- state  out  3  INIT=0, FETCH=1, DECODE=2, EXECUTE=3, EXECUTE2=4, HALT=5
- halted  out  1  high in HALT
- pc_clr, pc_inc, pc_ld, ir_ld, store_ld, nzp_ld  out  1 each  load strobes
- pc_data_sel  out  1  0=PC adder, 1=base register (rd0)
- pc_add_sel  out  1  0=PC+sext(IR[10:0]), 1=PC+sext(IR[8:0])
- mem_addr_sel  out  2  00=PC, 01=ALU result, 10=store register
- mem_w_en  out  1  memory write (data = rd1)
- rf_w_sel  out  2  00=PC, 01=memory read data, 10=ALU result
- rf_w_en  out  1  register file write
- rf_r_addr_0, rf_r_addr_1, rf_w_addr  out  3 each  register file addresses
- alu_a_sel  out  1  0=PC, 1=rd0
- alu_b_sel  out  1  0=rd1, 1=sign-extended immediate
- sext_sel  out  2  00=imm5, 01=offset6, 10=offset9, 11=offset11
- alu_sel  out  2  00=ADD, 01=AND, 10=PASS_A, 11=NOT
- nzp_sel  out  1  0=ALU result, 1=memory read data
- store_ld captures memory read data into the store register.

## Operation
- Outputs are combinational from state and ir. Any output not listed for a state is 0.
- INIT: pc_clr=1. Next state is FETCH.
- FETCH: mem_addr_sel=00, ir_ld=1, pc_inc=1. Next state is DECODE.
- DECODE: no strobes. Next state is HALT if ir[15:12]=1111; otherwise EXECUTE.
- EXECUTE, by opcode. PC-relative forms use the already-incremented PC.
  - ADD 0001 / AND 0101:
    - rd0=IR[8:6], rd1=IR[2:0]; alu_b_sel=IR[5], sext_sel=00.
    - Write ALU result to IR[11:9]; nzp_ld=1, nzp_sel=0.
  - NOT 1001: alu_sel=11, rd0=IR[8:6]. Write IR[11:9]; nzp_ld=1.
  - BR 0000: taken = (IR[11]&n)|(IR[10]&z)|(IR[9]&p). If taken: pc_ld=1, pc_data_sel=0, pc_add_sel=1.
  - JMP 1100: pc_ld=1, pc_data_sel=1, rd0=IR[8:6].
  - JSR 0100:
    - rf_w_en=1, rf_w_sel=00, rf_w_addr=7, pc_ld=1.
    - IR[11]=1: pc_data_sel=0, pc_add_sel=0. IR[11]=0: pc_data_sel=1, rd0=IR[8:6].
  - LD 0010 / LDR 0110:
    - Address = ALU ADD of (PC + offset9) or (rd0=IR[8:6] + offset6); mem_addr_sel=01.
    - rf_w_sel=01, write IR[11:9]; nzp_ld=1, nzp_sel=1.
  - LEA 1110: ALU = PC + offset9, written to IR[11:9]. NZP is not updated.
  - ST 0011 / STR 0111: same address as LD/LDR; mem_w_en=1, rd1=IR[11:9].
  - LDI 1010 / STI 1011: address = PC + offset9, mem_addr_sel=01, store_ld=1. Next state is EXECUTE2.
  - 1000 and 1101: NOP.
- EXECUTE2 (LDI/STI only): mem_addr_sel=10.
  - LDI: rf_w_sel=01, write IR[11:9], nzp_ld=1, nzp_sel=1.
  - STI: mem_w_en=1, rd1=IR[11:9].
- After EXECUTE (except LDI/STI) or EXECUTE2, next state is FETCH.
- HALT: halted=1, no strobes. Stays in HALT until rst.

## Timing
- rst asserted: state becomes INIT immediately, without waiting for a clock edge. All write enables drop that instant. pc_clr=1 while in INIT.
- First FETCH occurs on the first rising edge after rst deasserts. Memory address 0 is fetched.
- Cycles per instruction:
  - 3 (FETCH, DECODE, EXECUTE) for all instructions except LDI/STI.
  - 4 for LDI/STI.
  - HALT is reached 2 cycles after its FETCH.
- A register written in EXECUTE is readable in the next instruction's EXECUTE. No hazards, since there is one instruction in flight.
- JSRR with base R7: the target is the pre-write R7, because the read is combinational before the edge.
- BR with IR[11:9]=000 is never taken; with 111 it is always taken.
- rst in the middle of EXECUTE2 aborts the instruction. No memory or register write occurs after rst rises.

## Test plan
- Reset, then release rst:
  - state=0, pc_clr=1, mem_w_en=0, rf_w_en=0.
  - Next edge: state=1, ir_ld=1, pc_inc=1.
- ir=0x1283 (ADD R1,R2,R3) in EXECUTE:
  - rf_r_addr_0=2, rf_r_addr_1=3, alu_b_sel=0, alu_sel=00.
  - rf_w_addr=1, rf_w_en=1, nzp_ld=1. Returns to FETCH one cycle later.
- ir=0x0A05 (BRnp +5): z=1 gives pc_ld=0; n=1 gives pc_ld=1, pc_add_sel=1, pc_data_sel=0.
- ir=0xA403 (LDI R2):
  - EXECUTE: store_ld=1, mem_addr_sel=01.
  - EXECUTE2: mem_addr_sel=10, rf_w_sel=01, rf_w_addr=2, nzp_sel=1.
  - Total 4 cycles.
- ir=0x4FFE (JSR -2): rf_w_addr=7, rf_w_sel=00, rf_w_en=1, pc_ld=1, pc_add_sel=0.
- ir=0xF025 (TRAP):
  - DECODE goes to HALT; halted=1 and stays 1 for 10+ cycles with all strobes 0.
  - rst pulse mid-HALT returns state to 0.
